// File: rtl/mux_sel_arb_reg_if.sv
// Handshake bundle for mux_sel_arb_reg: N input channels in, one registered output.
interface mux_sel_arb_reg_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      opcode;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_chan;
  logic                 out_valid;
  logic                 out_ready;

  // Selector side
  modport slave (
    input  in_data, in_valid, mode, opcode, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  // Producer/consumer side
  modport master (
    output in_data, in_valid, mode, opcode, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/mux_sel_arb_reg.sv
// Registered N-channel selector: opcode-directed or round-robin grant into a
// single-entry valid/ready output register (1 transfer per cycle).
module mux_sel_arb_reg #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst,
  mux_sel_arb_reg_if.slave   bus
);

  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_chan;
  logic             r_out_valid;
  logic [SELW-1:0]  r_rr_ptr;

  logic [NCH-1:0]   w_rot;
  logic [SELW:0]    w_sum;
  logic [SELW-1:0]  w_grant;
  logic             w_gv;
  logic             w_load;
  logic [WIDTH-1:0] w_gdata;
  logic [NCH-1:0]   w_in_ready;

  // in_valid rotated so bit 0 is the channel at rr_ptr
  assign w_rot = NCH'({bus.in_valid, bus.in_valid} >> r_rr_ptr);

  // Grant selection: opcode in mode 0, first-valid-from-rr_ptr in mode 1
  always_comb begin
    w_grant = '0;
    w_gv    = 1'b0;
    w_sum   = '0;
    if (bus.mode) begin
      // descending scan so the lowest rotated offset wins
      for (int k = NCH-1; k >= 0; k--)
        if (w_rot[k]) w_sum = {1'b0, r_rr_ptr} + (SELW+1)'(k);
      if (w_sum >= (SELW+1)'(NCH)) w_sum = w_sum - (SELW+1)'(NCH);
      w_grant = w_sum[SELW-1:0];
      w_gv    = |bus.in_valid;
    end else begin
      w_grant = bus.opcode;
      // out-of-range opcodes never match, so they yield no grant
      for (int i = 0; i < NCH; i++)
        if (bus.opcode == SELW'(i)) w_gv = bus.in_valid[i];
    end
  end

  assign w_load = (!r_out_valid || bus.out_ready) && w_gv && !rst;

  // Per-channel ready and granted data mux
  always_comb begin
    w_in_ready = '0;
    w_gdata    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_grant == SELW'(i)) begin
        w_in_ready[i] = w_load;
        w_gdata       = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register, valid flag and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      r_out_data  <= w_gdata;
      r_out_chan  <= w_grant;
      r_out_valid <= 1'b1;
      if (bus.mode)
        r_rr_ptr <= (w_grant == SELW'(NCH-1)) ? '0 : w_grant + SELW'(1);
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_chan  = r_out_chan;
  assign bus.out_valid = r_out_valid;

endmodule
